uart_rx_mv: RTL and testbench
=============================

// Module: uart_rx_mv
//
// PURPOSE
// - Next-generation UART receiver: runtime baud divisor, 5..9 data bits, runtime parity and 1/2 stop bits.
// - 3-sample majority voting, start-glitch rejection, parity/framing/break flags per character.
// - Receive FIFO with valid/ready pop and an overrun pulse. Sits between the pad synchroniser-free rxd pin and the bus-side UART peripheral.
//
// PARAMETERS
// - PAYLOAD_BITS  8    data bits per character, legal 5..9
// - DIV_W         16   width of cfg_div
// - FIFO_DEPTH    4    receive FIFO entries, power of two, >= 2
//
// PORTS
// - clk           in   1             system clock; single clock domain
// - reset         in   1             synchronous, active-high reset
// - rx_en         in   1             receive enable
// - uart_rxd      in   1             asynchronous serial input, idle high
// - cfg_div       in   DIV_W         clk cycles per bit; values < 4 are treated as 4
// - cfg_parity    in   2             00 = none, 01 = even, 10 = odd, 11 = none
// - cfg_stop2     in   1             1 = two stop bits checked
// - m_valid       out  1             FIFO head valid
// - m_ready       in   1             consumer pops the head when m_valid & m_ready
// - m_data        out  PAYLOAD_BITS  received data, LSB first on the line
// - m_perr        out  1             parity error on this character
// - m_ferr        out  1             framing error (a stop bit sampled low)
// - m_break       out  1             break: data all zero, ferr set
// - overrun       out  1             one-cycle pulse when a character is dropped because the FIFO is full
// - busy          out  1             FSM not in IDLE
//
// BEHAVIOUR
// - Reset: all outputs 0; FIFO empty; FSM in IDLE; synchroniser flops set to 1.
// - Input path: uart_rxd passes through a 2-flop synchroniser to give rxs. The synchroniser runs always; rx_en does not gate it.
// - Configuration: cfg_div, cfg_parity and cfg_stop2 are latched on the start-edge detect. Changes mid-frame have no effect.
// - Bit timing: cycle counter cc runs 0..div-1, one bit per wrap.
//   - h = div/2 (integer).
//   - Samples are taken at cc = h-1, h, h+1; the bit value is the 2-of-3 majority.
//   - The majority is available at cc = h+1.
// - FSM states: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
//   - IDLE -> START: rx_en & rxs == 0. cc is cleared.
//   - START -> IDLE: majority == 1 (glitch). No push.
//   - START -> DATA: majority == 0, at wrap.
//   - DATA: shift in PAYLOAD_BITS bits LSB first. -> PARITY if parity is enabled, else -> STOP, at the wrap after the last bit.
//   - PARITY: perr = majority ^ (^data) ^ odd. -> STOP at wrap.
//   - STOP: check 1 or 2 stop bits; ferr if any stop majority == 0.
//     - Exit at cc = h+1 of the last stop bit; the rest of the bit is not waited out, so the receiver resyncs early.
//     - Push {break, ferr, perr, data}.
//     - -> BRKWAIT if break, else -> IDLE.
//   - BRKWAIT: hold until rxs == 1, then -> IDLE. Exactly one entry is pushed per break.
//   - rx_en low in any state except IDLE: -> IDLE next cycle. The partial frame is discarded; FIFO contents are kept.
// - Latency: m_valid rises 1 cycle after the push cycle (cc = h+1 of the last stop bit) when the FIFO was empty.
// - FIFO:
//   - Show-ahead: m_* outputs are stable while m_valid & !m_ready.
//   - Push when full: the character is dropped and overrun pulses for 1 cycle.
//   - Push and pop in the same cycle while full: both succeed, no overrun.
//   - Push and pop in the same cycle while empty: the push succeeds and m_valid rises next cycle.
//   - Pointer widths are $clog2(FIFO_DEPTH)+1 and wrap naturally. The extra MSB distinguishes full from empty.
// - Reset mid-frame: everything returns to the reset state on the next clock edge. The partial frame and all FIFO entries are lost.
//
// STRUCTURE
// - Package uart_pkg:
//   - state encodings for the FSM;
//   - parity encodings PAR_NONE, PAR_EVEN, PAR_ODD;
//   - MIN_DIV = 4;
//   - the FIFO entry layout (PAYLOAD_BITS+3 bits: {break, ferr, perr, data}).
// - Sub-module uart_rx_fifo: generic synchronous FIFO (WIDTH, DEPTH) providing the valid/ready pop and a full flag.
// - Synchroniser, counters, majority vote and FSM live in uart_rx_mv.
//
// TESTING
// - T1: div=8, no parity, 1 stop, send 0xA5 -> one entry, data=0xA5, perr=ferr=brk=0; m_valid 1 cycle after the last-stop mid-sample.
// - T2: even parity, send 0x3C with parity bit 1 -> perr=1; with parity bit 0 -> perr=0. Odd parity, 0x3C with bit 1 -> perr=0.
// - T3: cfg_stop2=1, second stop bit driven low -> ferr=1, data intact. 1-stop mode with the same waveform -> ferr=0.
// - T4: line low for 12 bit times -> exactly one entry {brk=1, ferr=1, data=0}. No further entries until the line has returned high and a new frame has been sent.
// - T5: 2-cycle low glitch at div=16 -> no entry, busy returns to 0. One of three samples low mid-bit -> majority value is kept.
// - T6: FIFO_DEPTH=4, m_ready=0, send 0x01..0x05 -> 4 entries 0x01..0x04 and one overrun pulse. Then reset mid-frame -> m_valid=0, busy=0 next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the multi-voting UART receiver: FSM states, parity
// encodings, minimum divisor and the layout of a receive FIFO entry.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BRKWAIT
   } rx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int MIN_DIV = 4;

   // Status flags sit directly above the data field: {break, ferr, perr, data}.
   localparam int ENTRY_PERR_OFS = 0;
   localparam int ENTRY_FERR_OFS = 1;
   localparam int ENTRY_BRK_OFS  = 2;

   function automatic int entry_width(input int payload_bits);
      return payload_bits + 3;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic show-ahead synchronous FIFO with valid/ready pop and a full flag.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module uart_rx_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             pop;
   logic             wr_en;

   assign m_valid = (wr_ptr != rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = m_valid & m_ready;
   assign wr_en   = push & (~full | pop);
   assign m_data  = m_valid ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define what
   // is valid, and m_data is masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_rx_mv.sv
// UART receiver with runtime divisor/parity/stop config, 3-sample majority
// voting, start-glitch rejection, break detection and a receive FIFO.
module uart_rx_mv
   import uart_pkg::*;
#(
   parameter int PAYLOAD_BITS = 8,
   parameter int DIV_W        = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rx_en,
   input  logic                    uart_rxd,
   input  logic [DIV_W-1:0]        cfg_div,
   input  logic [1:0]              cfg_parity,
   input  logic                    cfg_stop2,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [PAYLOAD_BITS-1:0] m_data,
   output logic                    m_perr,
   output logic                    m_ferr,
   output logic                    m_break,
   output logic                    overrun,
   output logic                    busy
);

   localparam int EW   = entry_width(PAYLOAD_BITS);
   localparam int BC_W = $clog2(PAYLOAD_BITS);

   rx_state_t               state, state_nxt;
   logic                    sync1, rxs;
   logic [DIV_W-1:0]        div_q, half, cc, div_eff;
   logic [1:0]              par_q;
   logic                    stop2_q;
   logic                    s0, s1, maj;
   logic                    at_s0, at_s1, at_mid, at_wrap;
   logic [PAYLOAD_BITS-1:0] shreg;
   logic [BC_W-1:0]         bit_cnt;
   logic                    stop_cnt;
   logic                    perr_q, ferr_q, ferr_now, brk_now;
   logic                    par_en, last_stop;
   logic                    start_det, push;
   logic                    fifo_full;
   logic [EW-1:0]           push_entry, head;

   assign div_eff   = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
   assign half      = div_q >> 1;
   assign at_s0     = (cc == half - DIV_W'(1));
   assign at_s1     = (cc == half);
   assign at_mid    = (cc == half + DIV_W'(1));
   assign at_wrap   = (cc == div_q - DIV_W'(1));
   assign maj       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
   assign par_en    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
   assign last_stop = (stop_cnt == stop2_q);
   assign ferr_now  = ferr_q | ~maj;
   assign brk_now   = ferr_now && (shreg == '0);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so that no path
   // through the case leaves a variable unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      start_det = 1'b0;
      push      = 1'b0;
      if (!rx_en) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  state_nxt = ST_START;
                  start_det = 1'b1;
               end
            end
            ST_START: begin
               if (at_mid && maj) state_nxt = ST_IDLE;
               else if (at_wrap)  state_nxt = ST_DATA;
            end
            ST_DATA: begin
               if (at_wrap && bit_cnt == BC_W'(PAYLOAD_BITS - 1))
                  state_nxt = par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
               if (at_wrap) state_nxt = ST_STOP;
            end
            ST_STOP: begin
               // Leave at the last stop mid-sample so the next start edge is caught early.
               if (at_mid && last_stop) begin
                  push      = 1'b1;
                  state_nxt = brk_now ? ST_BRKWAIT : ST_IDLE;
               end
            end
            ST_BRKWAIT: begin
               if (rxs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= 1'b1;
         rxs      <= 1'b1;
         cc       <= '0;
         div_q    <= DIV_W'(MIN_DIV);
         par_q    <= PAR_NONE;
         stop2_q  <= 1'b0;
         s0       <= 1'b1;
         s1       <= 1'b1;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         sync1   <= uart_rxd;
         rxs     <= sync1;
         overrun <= push & fifo_full & ~(m_valid & m_ready);
         if (start_det) begin
            div_q    <= div_eff;
            par_q    <= cfg_parity;
            stop2_q  <= cfg_stop2;
            cc       <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
         end else if (state != ST_IDLE) begin
            cc <= at_wrap ? '0 : cc + DIV_W'(1);
            if (at_s0) s0 <= rxs;
            if (at_s1) s1 <= rxs;
            if (state == ST_DATA && at_mid)
               shreg <= {maj, shreg[PAYLOAD_BITS-1:1]};
            if (state == ST_DATA && at_wrap)
               bit_cnt <= bit_cnt + BC_W'(1);
            if (state == ST_PARITY && at_mid)
               perr_q <= maj ^ (^shreg) ^ (par_q == PAR_ODD);
            if (state == ST_STOP && at_mid && !maj)
               ferr_q <= 1'b1;
            if (state == ST_STOP && at_wrap)
               stop_cnt <= 1'b1;
         end
      end
   end

   assign push_entry = {brk_now, ferr_now, perr_q, shreg};

   uart_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .full      (fifo_full),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (head)
   );

   assign m_data  = head[PAYLOAD_BITS-1:0];
   assign m_perr  = head[PAYLOAD_BITS + ENTRY_PERR_OFS];
   assign m_ferr  = head[PAYLOAD_BITS + ENTRY_FERR_OFS];
   assign m_break = head[PAYLOAD_BITS + ENTRY_BRK_OFS];

endmodule

// File: tb/tb_uart_rx_mv.sv
// Scoreboard bench for uart_rx_mv: expected entries {brk, ferr, perr, data}
// are queued at stimulus time and popped by a monitor on each FIFO handshake.
module tb_uart_rx_mv;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_en;
   logic        uart_rxd;
   logic [15:0] cfg_div;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_perr, m_ferr, m_break;
   logic        overrun;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ov_cnt = 0;
   int          rise_cyc = -1;
   int          frame_start = 0;
   logic        prev_valid = 1'b0;
   logic [10:0] sb[$];
   logic [10:0] mon_exp;

   uart_rx_mv #(
      .PAYLOAD_BITS (8),
      .DIV_W        (16),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_en      (rx_en),
      .uart_rxd   (uart_rxd),
      .cfg_div    (cfg_div),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_perr     (m_perr),
      .m_ferr     (m_ferr),
      .m_break    (m_break),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (overrun) ov_cnt++;
      if (m_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = m_valid;
      if (!reset && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry actual=0x%0h expected=none",
                     {m_break, m_ferr, m_perr, m_data});
         end else begin
            mon_exp = sb.pop_front();
            check("entry", {21'd0, m_break, m_ferr, m_perr, m_data}, {21'd0, mon_exp});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Waveform: start, 8 data bits LSB first, optional parity bit, stop bit(s),
   // then a long idle tail. One line cycle of bit g_bit at offset g_off is inverted.
   task automatic send_frame(input logic [7:0] data, input int div,
                             input bit has_par, input bit par_bit,
                             input bit two_stop, input bit stop2_val,
                             input int g_bit = -1, input int g_off = 0);
      logic [11:0] fb;
      int          nb;
      logic        v;
      fb = '1;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[1+i] = data[i];
      nb = 9;
      if (has_par) begin
         fb[nb] = par_bit;
         nb++;
      end
      fb[nb] = 1'b1;
      nb++;
      if (two_stop) begin
         fb[nb] = stop2_val;
         nb++;
      end
      frame_start = cyc;
      for (int i = 0; i < nb; i++) begin
         for (int c = 0; c < div; c++) begin
            v = fb[i];
            if (i == g_bit && c == g_off) v = ~v;
            uart_rxd = v;
            @(posedge clk);
            #1;
         end
      end
      uart_rxd = 1'b1;
      idle(12 * div);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (sb.size() != 0 && n < 4000);
      #1;
      check(name, sb.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ov_base;
      reset      = 1'b1;
      rx_en      = 1'b1;
      uart_rxd   = 1'b1;
      cfg_div    = 16'd8;
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;
      m_ready    = 1'b1;
      idle(4);
      check("rst_m_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_m_data", {m_break, m_ferr, m_perr, m_data}, 0);
      reset = 1'b0;
      idle(4);

      // T1: plain 8N1 frame; m_valid rises 81 cycles after the start bit is driven
      rise_cyc = -1;
      sb.push_back(11'h0A5);
      send_frame(8'hA5, 8, 0, 0, 0, 0);
      wait_drain("t1_drain");
      check("t1_latency", rise_cyc - frame_start, 81);

      // T2: parity
      cfg_parity = 2'b01;
      sb.push_back(11'h13C);
      send_frame(8'h3C, 8, 1, 1, 0, 0);
      sb.push_back(11'h03C);
      send_frame(8'h3C, 8, 1, 0, 0, 0);
      cfg_parity = 2'b10;
      sb.push_back(11'h03C);
      send_frame(8'h3C, 8, 1, 1, 0, 0);
      wait_drain("t2_drain");
      cfg_parity = 2'b00;

      // T3: second stop low. In 1-stop mode the low bit then reads as a new
      // start bit followed by an idle-high character 0xFF.
      cfg_stop2 = 1'b1;
      sb.push_back(11'h25A);
      send_frame(8'h5A, 8, 0, 0, 1, 0);
      wait_drain("t3_drain_stop2");
      cfg_stop2 = 1'b0;
      sb.push_back(11'h05A);
      sb.push_back(11'h0FF);
      send_frame(8'h5A, 8, 0, 0, 1, 0);
      wait_drain("t3_drain_stop1");

      // T4: break, one entry only, then a normal frame
      sb.push_back(11'h600);
      uart_rxd = 1'b0;
      idle(12 * 8);
      check("t4_busy_brkwait", busy, 1);
      uart_rxd = 1'b1;
      idle(2 * 8);
      sb.push_back(11'h033);
      send_frame(8'h33, 8, 0, 0, 0, 0);
      wait_drain("t4_drain");

      // T5: start glitch rejected; single-sample glitches outvoted
      cfg_div  = 16'd16;
      uart_rxd = 1'b0;
      idle(2);
      uart_rxd = 1'b1;
      idle(40);
      check("t5_glitch_busy", busy, 0);
      check("t5_glitch_noentry", sb.size(), 0);
      sb.push_back(11'h001);
      send_frame(8'h01, 16, 0, 0, 0, 0, 1, 9);
      sb.push_back(11'h081);
      send_frame(8'h81, 16, 0, 0, 0, 0, 3, 9);
      wait_drain("t5_drain");
      cfg_div = 16'd8;

      // T6: overrun with consumer stalled, then reset mid-frame
      m_ready = 1'b0;
      ov_base = ov_cnt;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) sb.push_back(11'(i));
         send_frame(8'(i), 8, 0, 0, 0, 0);
      end
      check("t6_overrun_count", ov_cnt - ov_base, 1);
      check("t6_m_valid", m_valid, 1);
      check("t6_head_hold", m_data, 8'h01);
      m_ready = 1'b1;
      wait_drain("t6_drain");
      m_ready = 1'b0;
      send_frame(8'h77, 8, 0, 0, 0, 0);
      check("t6_refill_valid", m_valid, 1);
      uart_rxd = 1'b0;
      idle(3 * 8);
      check("t6_busy_midframe", busy, 1);
      reset = 1'b1;
      idle(1);
      check("t6_rst_m_valid", m_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_m_data", m_data, 0);
      reset    = 1'b0;
      uart_rxd = 1'b1;
      idle(20);
      check("t6_post_rst_valid", m_valid, 0);
      check("final_sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
